sized_fifo_level: RTL and testbench

//  Parametrised synchronous FIFO, the successor to our fixed sized FIFO: arbitrary (non-power-of-two) depth,

---
 rtl/sized_fifo_level_pkg.sv | 38 +++
 rtl/sized_fifo_level_if.sv | 37 +++
 rtl/sized_fifo_level_mem_2p.sv | 32 +++
 rtl/sized_fifo_level.sv | 135 +++++++++++++
 tb/tb_sized_fifo_level.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sized_fifo_level_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sized_fifo_level_pkg
// Brief   : Shared types and helpers for the sized FIFO with occupancy level.
//           Holds the flag bundle, a constant clog2 and the non-power-of-two
//           pointer wrap helper.
// Revision: 1.0  initial release
// ============================================================================
package sized_fifo_level_pkg;

    // Status flags derived from the registered occupancy count
    typedef struct packed {
        logic full_n;
        logic empty_n;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Pointer increment that wraps at the FIFO depth, not at 2**width
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage : sized_fifo_level_pkg
`default_nettype wire

// File: rtl/sized_fifo_level_if.sv
`default_nettype none
// ============================================================================
// Module  : sized_fifo_level_if
// Brief   : Enqueue/dequeue handshake and status bundle of the sized FIFO.
//           master = producer/consumer side, slave = FIFO side.
// Revision: 1.0  initial release
// ============================================================================
interface sized_fifo_level_if #(
    parameter int p1width      = 32,
    parameter int p3cntr_width = 3
);
    logic                    clr;
    logic [p1width-1:0]      d_in;
    logic                    enq;
    logic                    full_n;
    logic [p1width-1:0]      d_out;
    logic                    deq;
    logic                    empty_n;
    logic [p3cntr_width:0]   count;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    err_ovf;
    logic                    err_udf;

    modport master (
        output clr, d_in, enq, deq,
        input  full_n, d_out, empty_n, count,
        input  almost_full, almost_empty, err_ovf, err_udf
    );

    modport slave (
        input  clr, d_in, enq, deq,
        output full_n, d_out, empty_n, count,
        output almost_full, almost_empty, err_ovf, err_udf
    );
endinterface : sized_fifo_level_if
`default_nettype wire

// File: rtl/sized_fifo_level_mem_2p.sv
`default_nettype none
// ============================================================================
// Module  : fifo_mem_2p
// Brief   : Storage array for the sized FIFO: one synchronous write port and
//           one asynchronous read port. The array itself is never reset.
// Revision: 1.0  initial release
// ============================================================================
module fifo_mem_2p #(
    parameter int p1width      = 32,
    parameter int p2depth      = 5,
    parameter int p3cntr_width = 3
) (
    input  wire logic                    clk,
    input  wire logic                    we,
    input  wire logic [p3cntr_width-1:0] waddr,
    input  wire logic [p1width-1:0]      wdata,
    input  wire logic [p3cntr_width-1:0] raddr,
    output      logic [p1width-1:0]      rdata
);
    logic [p1width-1:0] r_mem [0:p2depth-1];

    // Write port: capture enqueue data at the write pointer
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so the head is visible without a read cycle
    assign rdata = r_mem[raddr];
endmodule : fifo_mem_2p
`default_nettype wire

// File: rtl/sized_fifo_level.sv
`default_nettype none
// ============================================================================
// Module  : sized_fifo_level
// Brief   : First-word-fall-through FIFO of arbitrary depth with occupancy
//           count, almost-full/almost-empty flags and optional sticky
//           overflow/underflow error flags.
// Revision: 1.0  initial release
// ============================================================================
module sized_fifo_level
    import sized_fifo_level_pkg::*;
#(
    parameter int p1width      = 32,
    parameter int p2depth      = 5,
    parameter int p3cntr_width = 3,
    parameter bit guarded      = 1'b1,
    parameter int AF_MARGIN    = 1,
    parameter int AE_MARGIN    = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sized_fifo_level_if.slave bus
);
    localparam int c_ptr_w = p3cntr_width;
    localparam int c_cnt_w = p3cntr_width + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(p2depth);
    localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(p2depth - AF_MARGIN);
    localparam logic [c_cnt_w-1:0] c_ae    = c_cnt_w'(AE_MARGIN);

    // Parameter sanity: the count must be able to hold p2depth itself
    if (p3cntr_width < clog2(p2depth + 1)) begin : g_bad_cntr_width
        $error("sized_fifo_level: 2**p3cntr_width must exceed p2depth");
    end
    if (AF_MARGIN >= p2depth || AE_MARGIN >= p2depth) begin : g_bad_margin
        $error("sized_fifo_level: AF_MARGIN/AE_MARGIN must be below p2depth");
    end

    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    fifo_flags_t        w_flags;
    logic               w_enq_fire;
    logic               w_deq_fire;
    logic [p1width-1:0] w_rd_data;
    logic               w_err_ovf;
    logic               w_err_udf;

    // Flags come from the registered count only, never from this cycle's requests
    always_comb begin
        w_flags.full_n       = (r_count != c_depth);
        w_flags.empty_n      = (r_count != '0);
        w_flags.almost_full  = (r_count >= c_af);
        w_flags.almost_empty = (r_count <= c_ae);
    end

    assign w_enq_fire = bus.enq & w_flags.full_n;
    assign w_deq_fire = bus.deq & w_flags.empty_n;

    // Pointers and occupancy; flush wins over any request in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= c_ptr_w'(next_ptr(32'(r_wr_ptr), p2depth));
            end
            if (w_deq_fire) begin
                r_rd_ptr <= c_ptr_w'(next_ptr(32'(r_rd_ptr), p2depth));
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    if (guarded) begin : g_err_tied
        assign w_err_ovf = 1'b0;
        assign w_err_udf = 1'b0;
    end else begin : g_err_track
        logic r_err_ovf;
        logic r_err_udf;

        // Sticky misuse flags, cleared only by flush or reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_err_ovf <= 1'b0;
                r_err_udf <= 1'b0;
            end else if (bus.clr) begin
                r_err_ovf <= 1'b0;
                r_err_udf <= 1'b0;
            end else begin
                if (bus.enq && !w_flags.full_n) begin
                    r_err_ovf <= 1'b1;
                end
                if (bus.deq && !w_flags.empty_n) begin
                    r_err_udf <= 1'b1;
                end
            end
        end

        assign w_err_ovf = r_err_ovf;
        assign w_err_udf = r_err_udf;
    end

    fifo_mem_2p #(
        .p1width      (p1width),
        .p2depth      (p2depth),
        .p3cntr_width (p3cntr_width)
    ) u_mem (
        .clk   (clk),
        .we    (w_enq_fire & ~bus.clr),
        .waddr (r_wr_ptr),
        .wdata (bus.d_in),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

    // Head is masked to zero while empty so stale array contents never leak out
    assign bus.d_out        = w_flags.empty_n ? w_rd_data : '0;
    assign bus.full_n       = w_flags.full_n;
    assign bus.empty_n      = w_flags.empty_n;
    assign bus.count        = r_count;
    assign bus.almost_full  = w_flags.almost_full;
    assign bus.almost_empty = w_flags.almost_empty;
    assign bus.err_ovf      = w_err_ovf;
    assign bus.err_udf      = w_err_udf;
endmodule : sized_fifo_level
`default_nettype wire

// File: tb/tb_sized_fifo_level.sv
`default_nettype none
// ============================================================================
// Module  : tb_sized_fifo_level
// Brief   : Directed self-checking bench for sized_fifo_level (depth 5,
//           unguarded so the sticky error flags are observable).
// Revision: 1.0  initial release
// ============================================================================
module tb_sized_fifo_level;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    sized_fifo_level_if #(.p1width(32), .p3cntr_width(3)) bus ();

    sized_fifo_level #(
        .p1width      (32),
        .p2depth      (5),
        .p3cntr_width (3),
        .guarded      (1'b0),
        .AF_MARGIN    (1),
        .AE_MARGIN    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven and outputs sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n    = 1'b0;
        bus.clr  = 1'b0;
        bus.enq  = 1'b1;
        bus.deq  = 1'b0;
        bus.d_in = 32'hDEAD;

        // Reset held with ENQ asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_count",   bus.count,   4'd0);
            check("rst_full_n",  bus.full_n,  1'b1);
            check("rst_empty_n", bus.empty_n, 1'b0);
            check("rst_d_out",   bus.d_out,   32'h0);
        end
        check("rst_almost_empty", bus.almost_empty, 1'b1);
        check("rst_almost_full",  bus.almost_full,  1'b0);
        check("rst_err_ovf",      bus.err_ovf,      1'b0);
        check("rst_err_udf",      bus.err_udf,      1'b0);
        bus.enq = 1'b0;
        rst_n   = 1'b1;
        tick();

        // Fill with 0x11..0x55
        for (int i = 0; i < 5; i++) begin
            bus.enq  = 1'b1;
            bus.d_in = (i + 1) * 32'h11;
            tick();
            check("fill_count",   bus.count,       4'(i + 1));
            check("fill_af",      bus.almost_full, (i + 1 >= 4));
            check("fill_full_n",  bus.full_n,      (i + 1 != 5));
            check("fill_head",    bus.d_out,       32'h11);
        end
        bus.d_in = 32'h66;
        tick();
        bus.enq = 1'b0;
        check("ovf_count",   bus.count,   4'd5);
        check("ovf_err_ovf", bus.err_ovf, 1'b1);

        // Drain and check order
        for (int i = 0; i < 5; i++) begin
            check("drain_d_out", bus.d_out, (i + 1) * 32'h11);
            bus.deq = 1'b1;
            tick();
            check("drain_count",   bus.count,        4'(4 - i));
            check("drain_ae",      bus.almost_empty, (4 - i <= 1));
            check("drain_empty_n", bus.empty_n,      (i != 4));
        end
        bus.deq = 1'b0;
        check("drain_d_out_zero", bus.d_out,   32'h0);
        check("drain_err_udf",    bus.err_udf, 1'b0);

        // Flush clears the sticky overflow flag
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_err_ovf", bus.err_ovf, 1'b0);

        // Wrap: 13 simultaneous ENQ/DEQ at count 2
        bus.enq = 1'b1;
        bus.d_in = 32'h100;
        tick();
        bus.d_in = 32'h101;
        tick();
        bus.deq = 1'b1;
        for (int k = 0; k < 13; k++) begin
            bus.d_in = 32'h102 + k;
            check("wrap_head",  bus.d_out, 32'h100 + k);
            tick();
            check("wrap_count", bus.count, 4'd2);
        end
        bus.enq = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("wrap_tail", bus.d_out, 32'h10D + k);
            tick();
        end
        bus.deq = 1'b0;
        check("wrap_empty", bus.count, 4'd0);

        // Full + ENQ + DEQ: only the dequeue fires
        bus.enq = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.d_in = 32'h21 + k;
            tick();
        end
        check("full_full_n", bus.full_n, 1'b0);
        bus.d_in = 32'hBB;
        bus.deq  = 1'b1;
        tick();
        bus.enq = 1'b0;
        check("fed_count",   bus.count,   4'd4);
        check("fed_full_n",  bus.full_n,  1'b1);
        check("fed_err_ovf", bus.err_ovf, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("fed_order", bus.d_out, 32'h22 + k);
            tick();
        end
        bus.deq = 1'b0;
        check("fed_drained", bus.empty_n, 1'b0);

        // Empty + ENQ + DEQ: only the enqueue fires, no bypass
        bus.enq  = 1'b1;
        bus.deq  = 1'b1;
        bus.d_in = 32'hAA;
        tick();
        bus.enq = 1'b0;
        bus.deq = 1'b0;
        check("eed_count",   bus.count,   4'd1);
        check("eed_d_out",   bus.d_out,   32'hAA);
        check("eed_err_udf", bus.err_udf, 1'b1);
        bus.deq = 1'b1;
        tick();
        bus.deq = 1'b0;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr2_err_udf", bus.err_udf, 1'b0);
        check("clr2_err_ovf", bus.err_ovf, 1'b0);

        // DEQ on empty sets a sticky underflow flag
        bus.deq = 1'b1;
        tick();
        bus.deq = 1'b0;
        check("udf_set",   bus.err_udf, 1'b1);
        check("udf_count", bus.count,   4'd0);
        tick();
        check("udf_sticky", bus.err_udf, 1'b1);

        // CLR at count 3, with a competing ENQ
        bus.enq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.d_in = 32'h31 + k;
            tick();
        end
        check("pre_clr_count", bus.count, 4'd3);
        check("pre_clr_head",  bus.d_out, 32'h31);
        bus.d_in = 32'h34;
        bus.clr  = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.enq = 1'b0;
        check("clr_count",   bus.count,        4'd0);
        check("clr_err_udf", bus.err_udf,      1'b0);
        check("clr_empty_n", bus.empty_n,      1'b0);
        check("clr_d_out",   bus.d_out,        32'h0);
        check("clr_ae",      bus.almost_empty, 1'b1);
        check("clr_full_n",  bus.full_n,       1'b1);

        // Asynchronous reset in the middle of a fill
        bus.enq = 1'b1;
        bus.d_in = 32'h41;
        tick();
        bus.d_in = 32'h42;
        tick();
        bus.enq = 1'b0;
        check("mid_count", bus.count, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count",   bus.count,   4'd0);
        check("async_empty_n", bus.empty_n, 1'b0);
        check("async_d_out",   bus.d_out,   32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_count", bus.count,        4'd0);
        check("post_rst_ae",    bus.almost_empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_sized_fifo_level
`default_nettype wire
